spawn_scheduler: RTL and testbench

- Round-robin scheduler that shares the constrained dual random-coordinate generator among N_REQ spawn requesters (fruit, ghost respawn, power pellets).
- Per request: samples the free-running random X/Y pair, snaps it to the tile grid and rejects positions too close to Pac-Man.
- Rejects positions that land on a wall by querying the maze ROM, with a fixed latency of ROM_LAT cycles.
- Retries up to MAX_TRIES times, then returns a default position flagged as failed.

---
 rtl/spawn_scheduler_if.sv | 30 +++
 rtl/spawn_scheduler.sv | 165 ++++++++++++++++
 tb/tb_spawn_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spawn_scheduler_if.sv
// Bundle of request, random-source, Pac-Man position, maze-ROM and result
// signals shared between the spawn scheduler and its environment.
interface spawn_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [9:0]       x_rand;
  logic [9:0]       y_rand;
  logic [9:0]       pac_x;
  logic [9:0]       pac_y;
  logic             qry_valid;
  logic [9:0]       qry_x;
  logic [9:0]       qry_y;
  logic             qry_wall;
  logic [N_REQ-1:0] ack;
  logic [9:0]       spawn_x;
  logic [9:0]       spawn_y;
  logic             spawn_fail;
  logic             busy;

  modport master (
    output req, x_rand, y_rand, pac_x, pac_y, qry_wall,
    input  qry_valid, qry_x, qry_y, ack, spawn_x, spawn_y, spawn_fail, busy
  );

  modport slave (
    input  req, x_rand, y_rand, pac_x, pac_y, qry_wall,
    output qry_valid, qry_x, qry_y, ack, spawn_x, spawn_y, spawn_fail, busy
  );
endinterface

// File: rtl/spawn_scheduler.sv
// Round-robin spawn-position scheduler: samples random tile positions, rejects
// those near Pac-Man or on walls, and falls back to a default after MAX_TRIES.
module spawn_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned ROM_LAT   = 2,
  parameter logic [9:0]  MIN_DIST  = 10'd64,
  parameter logic [9:0]  DEF_X     = 10'd320,
  parameter logic [9:0]  DEF_Y     = 10'd240
) (
  input logic              Clk,
  input logic              Reset,
  spawn_scheduler_if.slave bus
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned WAIT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, DIST, WAIT, DONE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [TRY_W-1:0]  tries_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [9:0]        cx_q;
  logic [9:0]        cy_q;
  logic              near_q;
  logic              qry_valid_q;
  logic [9:0]        qry_x_q;
  logic [9:0]        qry_y_q;
  logic [N_REQ-1:0]  ack_q;
  logic [9:0]        spawn_x_q;
  logic [9:0]        spawn_y_q;
  logic              spawn_fail_q;
  logic              busy_q;

  logic [9:0]        cx_d;
  logic [9:0]        cy_d;
  logic signed [10:0] diff_x_d;
  logic signed [10:0] diff_y_d;
  logic signed [10:0] dist_x_d;
  logic signed [10:0] dist_y_d;
  logic              near_d;
  logic              grant_found_d;
  logic [IDX_W-1:0]  grant_d;
  logic              last_wait_d;
  logic              reject_d;
  logic              accept_d;
  logic              give_up_d;

  logic unused_rand_lsbs;
  assign unused_rand_lsbs = ^{bus.x_rand[3:0], bus.y_rand[3:0]};

  // First asserted request at or after ptr, searching upward modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    int unsigned      idx;
    pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % N_REQ;
      if (r[idx[IDX_W-1:0]]) pick = idx[IDX_W-1:0];
    end
    return pick;
  endfunction

  always_comb begin
    cx_d          = {bus.x_rand[9:4], 4'b0000};
    cy_d          = {bus.y_rand[9:4], 4'b0000};
    diff_x_d      = $signed({1'b0, cx_d}) - $signed({1'b0, bus.pac_x});
    diff_y_d      = $signed({1'b0, cy_d}) - $signed({1'b0, bus.pac_y});
    dist_x_d      = diff_x_d[10] ? -diff_x_d : diff_x_d;
    dist_y_d      = diff_y_d[10] ? -diff_y_d : diff_y_d;
    near_d        = (dist_x_d < $signed({1'b0, MIN_DIST})) &&
                    (dist_y_d < $signed({1'b0, MIN_DIST}));
    grant_found_d = |bus.req;
    grant_d       = rr_pick(bus.req, rr_ptr_q);
    last_wait_d   = (state_q == WAIT) && (wait_cnt_q == WAIT_W'(1));
    reject_d      = ((state_q == DIST) && near_q) || (last_wait_d && bus.qry_wall);
    accept_d      = last_wait_d && !bus.qry_wall;
    give_up_d     = (tries_q == TRY_W'(MAX_TRIES));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      tries_q      <= '0;
      wait_cnt_q   <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      near_q       <= 1'b0;
      qry_valid_q  <= 1'b0;
      qry_x_q      <= '0;
      qry_y_q      <= '0;
      ack_q        <= '0;
      spawn_x_q    <= '0;
      spawn_y_q    <= '0;
      spawn_fail_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ack_q       <= '0;
      qry_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found_d) begin
            grant_q <= grant_d;
            tries_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SAMPLE;
          end
        end
        // Distance is judged here so the ROM strobe is registered into DIST.
        SAMPLE: begin
          cx_q    <= cx_d;
          cy_q    <= cy_d;
          near_q  <= near_d;
          tries_q <= tries_q + TRY_W'(1);
          state_q <= DIST;
          if (!near_d) begin
            qry_valid_q <= 1'b1;
            qry_x_q     <= cx_d;
            qry_y_q     <= cy_d;
          end
        end
        DIST: begin
          if (!near_q) begin
            wait_cnt_q <= WAIT_W'(ROM_LAT);
            state_q    <= WAIT;
          end
        end
        WAIT: wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
        DONE: begin
          rr_ptr_q <= (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + IDX_W'(1);
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Rejects either retry or fall back in the cycle they are detected.
      if (reject_d && !give_up_d) state_q <= SAMPLE;
      if (accept_d || (reject_d && give_up_d)) begin
        state_q      <= DONE;
        ack_q        <= N_REQ'(1) << grant_q;
        spawn_x_q    <= accept_d ? cx_q : DEF_X;
        spawn_y_q    <= accept_d ? cy_q : DEF_Y;
        spawn_fail_q <= !accept_d;
      end
    end
  end

  assign bus.qry_valid  = qry_valid_q;
  assign bus.qry_x      = qry_x_q;
  assign bus.qry_y      = qry_y_q;
  assign bus.ack        = ack_q;
  assign bus.spawn_x    = spawn_x_q;
  assign bus.spawn_y    = spawn_y_q;
  assign bus.spawn_fail = spawn_fail_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed scenarios plus randomized transactions,
// each predicted cycle by cycle from a timeline model of the scheduling rules.
module tb_spawn_scheduler;
  localparam int unsigned N_REQ     = 4;
  localparam int unsigned MAX_TRIES = 8;
  localparam int unsigned ROM_LAT   = 2;
  localparam int          MIN_D     = 64;
  localparam int          DEFX      = 320;
  localparam int          DEFY      = 240;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  spawn_scheduler_if #(.N_REQ(N_REQ)) bus ();

  spawn_scheduler #(
    .N_REQ(N_REQ), .MAX_TRIES(MAX_TRIES), .ROM_LAT(ROM_LAT),
    .MIN_DIST(10'd64), .DEF_X(10'd320), .DEF_Y(10'd240)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int          n_chk   = 0;
  int          n_fail  = 0;
  int          exp_rr  = 0;
  logic [20:0] last_sp = '0;
  logic [9:0]  xr [64];
  logic [9:0]  yr [64];
  bit          wall_map [64][64];
  bit          wall_all = 1'b0;
  bit          jitter   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic bit maze(input int x, input int y);
    return wall_all ? 1'b1 : wall_map[x / 16][y / 16];
  endfunction

  task automatic fill(input int x, input int y);
    for (int i = 0; i < 64; i++) begin
      xr[i] = 10'(x);
      yr[i] = 10'(y);
    end
  endtask

  // One transaction starting at the next negedge (DUT idle). xr/yr[t] drive cycle t.
  task automatic run_txn(input logic [3:0] req_v, input string tag,
                         output int g_dut, output int ack_dut, output int nq_dut);
    int g, t, tries, nxt, ack_t, cx, cy, dx, dy, sx, sy, nq_exp;
    bit near, fail, done;
    logic [3:0] sh;
    bit exp_qv [64];
    int exp_qx [64];
    int exp_qy [64];
    bit sched_v [64];
    bit sched_w [64];

    g = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sh = req_v >> ((exp_rr + i) % N_REQ);
      if (sh[0]) g = (exp_rr + i) % N_REQ;
    end
    for (int i = 0; i < 64; i++) begin
      exp_qv[i] = 1'b0; exp_qx[i] = 0; exp_qy[i] = 0;
      sched_v[i] = 1'b0; sched_w[i] = 1'b0;
    end

    // Timeline: sample at t, query at t+1, next sample or completion later.
    t = 1; tries = 0; done = 1'b0; ack_t = 0; fail = 1'b0; sx = 0; sy = 0; nq_exp = 0;
    while (!done) begin
      cx = (int'(xr[t]) / 16) * 16;
      cy = (int'(yr[t]) / 16) * 16;
      tries++;
      dx = cx - int'(bus.pac_x); if (dx < 0) dx = -dx;
      dy = cy - int'(bus.pac_y); if (dy < 0) dy = -dy;
      near = (dx < MIN_D) && (dy < MIN_D);
      nxt = near ? t + 2 : t + 2 + int'(ROM_LAT);
      if (!near) begin
        exp_qv[t+1] = 1'b1; exp_qx[t+1] = cx; exp_qy[t+1] = cy; nq_exp++;
        if (!maze(cx, cy)) begin done = 1'b1; ack_t = nxt; sx = cx; sy = cy; end
      end
      if (!done && tries == int'(MAX_TRIES)) begin
        done = 1'b1; ack_t = nxt; fail = 1'b1; sx = DEFX; sy = DEFY;
      end
      t = nxt;
    end

    g_dut = -1; ack_dut = -1; nq_dut = 0;
    for (t = 0; t <= ack_t; t++) begin
      @(negedge Clk);
      if (t == 0) begin
        chk({tag, " idle busy"}, 32'(bus.busy), 32'(0));
        chk({tag, " idle ack"}, 32'(bus.ack), 32'(0));
        chk({tag, " idle qry_valid"}, 32'(bus.qry_valid), 32'(0));
        bus.req = req_v;
      end else begin
        chk({tag, " busy"}, 32'(bus.busy), 32'(1));
        chk({tag, " qry_valid"}, 32'(bus.qry_valid), 32'(exp_qv[t]));
        if (exp_qv[t]) begin
          chk({tag, " qry_x"}, 32'(bus.qry_x), 32'(exp_qx[t]));
          chk({tag, " qry_y"}, 32'(bus.qry_y), 32'(exp_qy[t]));
        end
        chk({tag, " ack"}, 32'(bus.ack), (t == ack_t) ? (32'(1) << g) : 32'(0));
        if (bus.qry_valid === 1'b1) begin
          nq_dut++;
          sched_v[t + int'(ROM_LAT)] = 1'b1;
          sched_w[t + int'(ROM_LAT)] = maze(int'(bus.qry_x), int'(bus.qry_y));
        end
        if (bus.ack !== 4'b0000 && ack_dut < 0) begin
          ack_dut = t;
          for (int i = 0; i < int'(N_REQ); i++) begin
            sh = bus.ack >> i;
            if (sh[0] === 1'b1) g_dut = i;
          end
        end
        if (t == ack_t) begin
          chk({tag, " spawn_x"}, 32'(bus.spawn_x), 32'(sx));
          chk({tag, " spawn_y"}, 32'(bus.spawn_y), 32'(sy));
          chk({tag, " spawn_fail"}, 32'(bus.spawn_fail), 32'(fail));
        end else if (jitter) begin
          bus.req = 4'($urandom);
        end
      end
      if (t < ack_t)
        chk({tag, " spawn held"}, 32'({bus.spawn_fail, bus.spawn_y, bus.spawn_x}), 32'(last_sp));
      bus.x_rand   = xr[t];
      bus.y_rand   = yr[t];
      bus.qry_wall = sched_v[t] ? sched_w[t] : 1'($urandom);
    end
    chk({tag, " query count"}, 32'(nq_dut), 32'(nq_exp));
    last_sp = {fail, 10'(sy), 10'(sx)};
    exp_rr  = (g + 1) % int'(N_REQ);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"}, 32'(bus.ack), 32'(0));
    chk({tag, " qry_valid"}, 32'(bus.qry_valid), 32'(0));
    chk({tag, " qry_xy"}, 32'({bus.qry_y, bus.qry_x}), 32'(0));
    chk({tag, " spawn"}, 32'({bus.spawn_fail, bus.spawn_y, bus.spawn_x}), 32'(0));
    chk({tag, " busy"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    int g, a, nq, v;
    bus.req = '0; bus.x_rand = '0; bus.y_rand = '0;
    bus.pac_x = '0; bus.pac_y = '0; bus.qry_wall = 1'b0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) wall_map[i][j] = ($urandom_range(99) < 30);
    wall_map[12][6]  = 1'b0;
    wall_map[43][31] = 1'b0;

    #3;
    chk_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Single request, far from Pac-Man, free tile.
    fill(200, 100); bus.pac_x = 10'd500; bus.pac_y = 10'd400;
    run_txn(4'b0001, "single", g, a, nq);
    chk("single ack cycle", 32'(a), 32'(5));
    chk("single grant", 32'(g), 32'(0));

    // Reset asserted asynchronously while waiting on the ROM.
    @(negedge Clk); bus.req = 4'b0001; bus.x_rand = 10'd200; bus.y_rand = 10'd100;
    @(negedge Clk);
    @(negedge Clk); chk("midrst qry_valid", 32'(bus.qry_valid), 32'(1));
    @(negedge Clk); chk("midrst busy", 32'(bus.busy), 32'(1));
    #2 Reset = 1'b1;
    #1 chk_all_zero("midrst async");
    bus.req = '0; bus.qry_wall = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("post reset ack", 32'(bus.ack), 32'(0));
      chk("post reset busy", 32'(bus.busy), 32'(0));
    end
    exp_rr = 0; last_sp = '0;
    run_txn(4'b0001, "single again", g, a, nq);
    chk("single again ack cycle", 32'(a), 32'(5));

    // Distance boundary cases around sample (192,96).
    bus.pac_x = 10'd256; bus.pac_y = 10'd160;
    run_txn(4'b0001, "dist 64/64", g, a, nq);
    chk("dist 64/64 ack cycle", 32'(a), 32'(5));
    bus.pac_x = 10'd255;
    run_txn(4'b0001, "dist 63/64", g, a, nq);
    chk("dist 63/64 ack cycle", 32'(a), 32'(5));
    bus.pac_x = 10'd250; bus.pac_y = 10'd150;
    xr[3] = 10'd700; yr[3] = 10'd500;
    run_txn(4'b0001, "dist near", g, a, nq);
    chk("dist near ack cycle", 32'(a), 32'(7));
    chk("dist near queries", 32'(nq), 32'(1));

    // Every query hits a wall: exhaust tries and fall back.
    wall_all = 1'b1; bus.pac_x = '0; bus.pac_y = '0;
    for (int i = 0; i < 64; i++) begin
      xr[i] = 10'($urandom_range(1023, 128));
      yr[i] = 10'($urandom_range(1023, 128));
    end
    run_txn(4'b0001, "exhaust", g, a, nq);
    chk("exhaust queries", 32'(nq), 32'(8));
    chk("exhaust ack cycle", 32'(a), 32'(33));
    chk("exhaust spawn", 32'({bus.spawn_fail, bus.spawn_y, bus.spawn_x}), {11'd0, 1'b1, 10'd240, 10'd320});
    wall_all = 1'b0;

    // Round robin from pointer 0, then stuck requester.
    fill(200, 100); bus.pac_x = 10'd500; bus.pac_y = 10'd400;
    run_txn(4'b1000, "rr align", g, a, nq);
    run_txn(4'b1111, "rr0", g, a, nq); chk("rr0 grant", 32'(g), 32'(0));
    run_txn(4'b1110, "rr1", g, a, nq); chk("rr1 grant", 32'(g), 32'(1));
    run_txn(4'b1100, "rr2", g, a, nq); chk("rr2 grant", 32'(g), 32'(2));
    run_txn(4'b1000, "rr3", g, a, nq); chk("rr3 grant", 32'(g), 32'(3));
    run_txn(4'b1001, "rr4", g, a, nq); chk("rr4 grant", 32'(g), 32'(0));
    run_txn(4'b1000, "rr5", g, a, nq); chk("rr5 grant", 32'(g), 32'(3));
    run_txn(4'b0100, "stuck0", g, a, nq); chk("stuck0 grant", 32'(g), 32'(2));
    run_txn(4'b0101, "stuck1", g, a, nq); chk("stuck1 grant", 32'(g), 32'(0));
    run_txn(4'b0100, "stuck2", g, a, nq); chk("stuck2 grant", 32'(g), 32'(2));

    // Randomized transactions with request churn while busy.
    jitter = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bus.pac_x = 10'($urandom); bus.pac_y = 10'($urandom);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(2) == 0) begin
          v = int'(bus.pac_x) + int'($urandom_range(160)) - 80;
          xr[i] = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
          v = int'(bus.pac_y) + int'($urandom_range(160)) - 80;
          yr[i] = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
        end else begin
          xr[i] = 10'($urandom);
          yr[i] = 10'($urandom);
        end
      end
      run_txn(4'($urandom_range(15, 1)), "random", g, a, nq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
